// File: rtl/panel_key_seq_pkg.sv
// panel_key_seq_pkg: key codes, sequencer state encoding and code-to-one-hot mapping shared by the panel logic
package panel_key_seq_pkg;

    localparam logic [3:0] KEY_NONE      = 4'd0;
    localparam logic [3:0] KEY_START     = 4'd1;
    localparam logic [3:0] KEY_READ_IN   = 4'd2;
    localparam logic [3:0] KEY_MEM_CONT  = 4'd3;
    localparam logic [3:0] KEY_INST_CONT = 4'd4;
    localparam logic [3:0] KEY_MEM_STOP  = 4'd5;
    localparam logic [3:0] KEY_INST_STOP = 4'd6;
    localparam logic [3:0] KEY_EXEC      = 4'd7;
    localparam logic [3:0] KEY_IO_RESET  = 4'd8;
    localparam logic [3:0] KEY_DEP       = 4'd9;
    localparam logic [3:0] KEY_DEP_NXT   = 4'd10;
    localparam logic [3:0] KEY_EX        = 4'd11;
    localparam logic [3:0] KEY_EX_NXT    = 4'd12;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_HOLD = 2'd1,
        SEQ_GAP  = 2'd2
    } seq_state_t;

    function automatic logic key_code_valid(input logic [3:0] code);
        return (code >= KEY_START) && (code <= KEY_EX_NXT);
    endfunction

    // Code n drives key line n-1; invalid codes map to no key.
    function automatic logic [11:0] key_onehot(input logic [3:0] code);
        return key_code_valid(code) ? (12'd1 << (code - 4'd1)) : 12'd0;
    endfunction

endpackage

// File: rtl/panel_key_seq_timer.sv
// seq_timer: loadable down-counter that stops at zero
//   clk, reset (sync, active-low), clear (force 0), load/load_value (preload),
//   value (current count), zero (value == 0)
module seq_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    assign zero = (value == '0);

    always_ff @(posedge clk) begin
        if (!reset || clear)
            value <= '0;
        else if (load)
            value <= load_value;
        else if (!zero)
            value <= value - 1'b1;
    end

endmodule

// File: rtl/panel_key_seq.sv
// panel_key_seq: timed front-panel key sequencer, one exclusive fixed-width key pulse per command
//   clk, reset (sync, active-low)
//   cmd_valid/cmd_ready/cmd_key : command handshake, 4-bit key code
//   abort                       : drop current press/gap
//   keys                        : registered one-hot key lines (bit i = code i+1)
//   busy, done, err             : status; done/err are one-cycle pulses
module panel_key_seq
    import panel_key_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000,
    parameter int GAP_CYCLES  = 50000,
    parameter int CNT_W       = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic        abort,
    output logic [11:0] keys,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    seq_state_t       state, state_next;
    logic [11:0]      keys_next;
    logic             done_next, err_next;
    logic             accept;
    logic             t_clear, t_load, t_zero;
    logic [CNT_W-1:0] t_load_value, t_value;

    seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (t_clear),
        .load       (t_load),
        .load_value (t_load_value),
        .value      (t_value),
        .zero       (t_zero)
    );

    assign cmd_ready = (state == SEQ_IDLE) & reset & ~abort;
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state != SEQ_IDLE);

    always_comb begin
        state_next   = state;
        keys_next    = keys;
        done_next    = 1'b0;
        err_next     = 1'b0;
        t_clear      = 1'b0;
        t_load       = 1'b0;
        t_load_value = HOLD_LOAD;
        case (state)
            SEQ_IDLE: begin
                keys_next = 12'd0;
                if (accept) begin
                    err_next = ~key_code_valid(cmd_key);
                    if (key_code_valid(cmd_key)) begin
                        keys_next  = key_onehot(cmd_key);
                        t_load     = 1'b1;
                        state_next = SEQ_HOLD;
                    end
                end
            end
            SEQ_HOLD: begin
                if (abort) begin
                    keys_next  = 12'd0;
                    t_clear    = 1'b1;
                    state_next = SEQ_IDLE;
                end else if (t_zero) begin
                    keys_next    = 12'd0;
                    t_load       = 1'b1;
                    t_load_value = GAP_LOAD;
                    state_next   = SEQ_GAP;
                end
            end
            SEQ_GAP: begin
                keys_next  = 12'd0;
                t_clear    = abort;
                state_next = (abort || t_zero) ? SEQ_IDLE : SEQ_GAP;
                done_next  = ~abort & t_zero;
            end
            default: begin
                // Unreachable encoding: fall back to a quiet idle.
                keys_next  = 12'd0;
                t_clear    = 1'b1;
                state_next = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEQ_IDLE;
            keys  <= 12'd0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            keys  <= keys_next;
            done  <= done_next;
            err   <= err_next;
        end
    end

endmodule

// File: tb/tb_panel_key_seq.sv
// tb_panel_key_seq: directed self-checking bench for panel_key_seq with HOLD_CYCLES=4, GAP_CYCLES=3
module tb_panel_key_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_key;
    logic        abort;
    logic [11:0] keys;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    panel_key_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(3), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_key   (cmd_key),
        .abort     (abort),
        .keys      (keys),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_state(input string tag);
        check({tag, "_keys"}, 32'(keys), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_key = 4'd0;
        abort = 1'b0;
        tick();
        tick();
        idle_state("rst");
        check("rst_err", 32'(err), 32'h0);
        check("rst_ready_low", 32'(cmd_ready), 32'h0);
        reset = 1'b1;
        #1;
        check("rst_ready", 32'(cmd_ready), 32'h1);

        // 1: single press of start, key high t+1..t+4, done at t+8
        cmd_valid = 1'b1;
        cmd_key = 4'd1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t1_key_c%0d", i), 32'(keys), 32'h001);
            check($sformatf("t1_ready_c%0d", i), 32'(cmd_ready), 32'h0);
            tick();
        end
        for (int i = 5; i <= 7; i++) begin
            check($sformatf("t1_gap_c%0d", i), 32'(keys), 32'h0);
            check($sformatf("t1_gapbusy_c%0d", i), 32'(busy), 32'h1);
            check($sformatf("t1_gapdone_c%0d", i), 32'(done), 32'h0);
            tick();
        end
        check("t1_done", 32'(done), 32'h1);
        check("t1_ready", 32'(cmd_ready), 32'h1);
        check("t1_idle", 32'(busy), 32'h0);
        tick();
        check("t1_done_pulse", 32'(done), 32'h0);

        // 2: exec then ex_nxt, cmd_valid held throughout
        cmd_valid = 1'b1;
        cmd_key = 4'd7;
        tick();
        cmd_key = 4'd12;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_exec_c%0d", i), 32'(keys), 32'h040);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_gap_c%0d", i), 32'(keys), 32'h0);
            check($sformatf("t2_gapbusy_c%0d", i), 32'(busy), 32'h1);
            tick();
        end
        check("t2_done1", 32'(done), 32'h1);
        check("t2_ready1", 32'(cmd_ready), 32'h1);
        check("t2_gapkey_ready", 32'(keys), 32'h0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_exnxt_c%0d", i), 32'(keys), 32'h800);
            tick();
        end
        tick();
        tick();
        tick();
        check("t2_done2", 32'(done), 32'h1);
        tick();

        // 3: invalid codes 0 and 15
        cmd_valid = 1'b1;
        cmd_key = 4'd0;
        tick();
        check("t3_err0", 32'(err), 32'h1);
        check("t3_keys0", 32'(keys), 32'h0);
        check("t3_busy0", 32'(busy), 32'h0);
        cmd_key = 4'd15;
        tick();
        check("t3_err15", 32'(err), 32'h1);
        check("t3_keys15", 32'(keys), 32'h0);
        check("t3_busy15", 32'(busy), 32'h0);
        cmd_valid = 1'b0;
        tick();
        check("t3_err_pulse", 32'(err), 32'h0);

        // 4: abort during second hold cycle of dep, then abort blocking accept
        cmd_valid = 1'b1;
        cmd_key = 4'd9;
        tick();
        cmd_valid = 1'b0;
        check("t4_dep_c1", 32'(keys), 32'h100);
        tick();
        check("t4_dep_c2", 32'(keys), 32'h100);
        abort = 1'b1;
        tick();
        idle_state("t4_abort");
        check("t4_ready_blocked", 32'(cmd_ready), 32'h0);
        abort = 1'b0;
        #1;
        check("t4_ready", 32'(cmd_ready), 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t4_nodone_c%0d", i), 32'(done), 32'h0);
        end
        abort = 1'b1;
        cmd_valid = 1'b1;
        cmd_key = 4'd3;
        tick();
        idle_state("t4_abort_idle");
        abort = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("t4_pending", 32'(keys), 32'h004);
        for (int i = 0; i < 7; i++) tick();
        check("t4_pending_done", 32'(done), 32'h1);
        tick();

        // 5: reset mid-hold, then normal operation
        cmd_valid = 1'b1;
        cmd_key = 4'd5;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("t5_hold_c3", 32'(keys), 32'h010);
        reset = 1'b0;
        tick();
        idle_state("t5_reset");
        reset = 1'b1;
        tick();
        idle_state("t5_after");
        cmd_valid = 1'b1;
        cmd_key = 4'd4;
        tick();
        cmd_valid = 1'b0;
        check("t5_new_key", 32'(keys), 32'h008);
        for (int i = 0; i < 7; i++) tick();
        check("t5_new_done", 32'(done), 32'h1);
        tick();

        // 6: key change while busy and a valid pulse during gap are ignored
        cmd_valid = 1'b1;
        cmd_key = 4'd2;
        tick();
        cmd_valid = 1'b0;
        cmd_key = 4'd10;
        check("t6_key_c1", 32'(keys), 32'h002);
        tick();
        check("t6_key_c2", 32'(keys), 32'h002);
        tick();
        tick();
        check("t6_key_c4", 32'(keys), 32'h002);
        tick();
        check("t6_gap", 32'(keys), 32'h0);
        cmd_valid = 1'b1;
        cmd_key = 4'd11;
        tick();
        cmd_valid = 1'b0;
        check("t6_gap_pulse_keys", 32'(keys), 32'h0);
        check("t6_gap_pulse_busy", 32'(busy), 32'h1);
        tick();
        tick();
        check("t6_done", 32'(done), 32'h1);
        tick();
        idle_state("t6_not_latched");
        cmd_valid = 1'b1;
        cmd_key = 4'd12;
        tick();
        cmd_valid = 1'b0;
        check("t6_ready_accept", 32'(keys), 32'h800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
